fll_cfg_arb: RTL and testbench
==============================

// Module: fll_cfg_arb
// PURPOSE
//  Shares the single FLL config port (cfgreq/cfgack/cfgweb/cfgad/cfgd/cfgq) between NREQ requesters.
//  Typical requesters: the FLL range/opmode controller (index 0) and the debug/JTAG config path (index 1).
//  Arbitrates round-robin and captures the granted request into registers.
//  Runs the four-phase req/ack handshake and returns completion and read data to the owner.
// PARAMETERS
//  NREQ         2    number of requesters, 2..8
//  TIMEOUT_CYC  255  ack watchdog limit in ref_clk cycles; used only when FLL_CFG_ARB_TIMEOUT_EN is defined
// PORTS
//  ref_clk     in   1        single clock for the whole block
//  rst_n       in   1        reset, asynchronous, active-low
//  req_valid   in   NREQ     per-requester request; held high until its req_done
//  req_web     in   NREQ     per-requester write-enable-bar: 0=write, 1=read
//  req_ad      in   2*NREQ   per-requester register address; slice i = [2i+1:2i]
//  req_d       in   32*NREQ  per-requester write data; slice i = [32i+31:32i]
//  req_done    out  NREQ     one-cycle completion pulse to the owner
//  req_err     out  NREQ     one-cycle timeout flag, coincident with req_done; tied 0 without the macro
//  req_rdata   out  32       read data; valid in the req_done cycle
//  cfgreq      out  1        FLL config request (registered)
//  cfgweb      out  1        FLL write-enable-bar (registered)
//  cfgad       out  2        FLL config address (registered)
//  cfgd        out  32       FLL config write data (registered)
//  cfgack      in   1        FLL config acknowledge, level
//  cfgq        in   32       FLL config read data; valid while cfgack=1
// BEHAVIOUR
//  Reset values (async, immediate): state=IDLE, rr_ptr=0.
//   Outputs: cfgreq=0, cfgweb=1, cfgad=0, cfgd=0, req_done=0, req_err=0, req_rdata=0.
//  All outputs are registered.
//  FSM states:
//   IDLE: no owner.
//    - If any req_valid: grant the first set bit at or after rr_ptr, scanning upward with wrap.
//    - Latch owner index, web, ad and d into cfgweb/cfgad/cfgd.
//    - Set cfgreq=1 and go to REQ.
//   REQ: hold cfgreq=1 and cfgweb/cfgad/cfgd stable.
//    - On sampled cfgack=1: capture cfgq into rdata_q if web=1, else 0.
//    - Then cfgreq<=0, cfgweb<=1, go to RELEASE.
//   RELEASE: wait for cfgack=0.
//    - Then pulse req_done[owner], drive req_rdata=rdata_q.
//    - Set rr_ptr=(owner+1) mod NREQ and go to IDLE.
//  Latency, no contention:
//   - req_valid rises in cycle 0: cfgreq=1 in cycle 1.
//   - cfgack seen in cycle k: cfgreq=0 in cycle k+1.
//   - cfgack seen low in cycle m: req_done in cycle m+1.
//   - Next grant: at the earliest, cfgreq=1 in the cycle after req_done.
//  Requester obligations and robustness:
//   - Requester holds req_valid until it sees req_done.
//   - Deassert req_valid in the req_done cycle or the next cycle. Otherwise it is treated as a new request.
//   - Deasserting req_valid or changing req_ad/req_d mid-transaction has no effect; captured values are used.
//   - cfgack=1 while in IDLE is ignored; no grant is blocked by it.
//   - If cfgack is still 1 at grant time, REQ completes on that ack. The FLL contract forbids this case.
//   - Simultaneous requests: only the round-robin winner is granted; losers wait with req_valid held.
//   - Fairness: each waiting requester is served within NREQ transactions.
//   - Reset mid-transaction aborts with no req_done; cfgreq drops immediately.
//  Width rules:
//   - Owner index is $clog2(NREQ) bits; rr_ptr wraps from NREQ-1 to 0.
//   - Read data is 32 bits; no sign or width conversion.
// CONFIGURATION
//  FLL_CFG_ARB_TIMEOUT_EN defined:
//   - An 8..16-bit counter clears on entry to REQ, counts in REQ and RELEASE, and holds otherwise.
//   - When it reaches TIMEOUT_CYC, on the next cycle: req_done[owner]=1, req_err[owner]=1, req_rdata=0.
//   - Also cfgreq=0, cfgweb=1, and the FSM goes to IDLE with rr_ptr advanced.
//  FLL_CFG_ARB_TIMEOUT_EN undefined:
//   - No counter; a missing ack stalls the block until reset.
//   - req_err is constant 0.
// TESTING
//  T1 single write: req_valid[0]=1, web=0, ad=2'b01, d=32'hC088_0010; cfgack 2 cycles after cfgreq.
//     -> cfgreq=1, cfgweb=0, cfgad=01, cfgd=C0880010; req_done[0] pulses 1 cycle after cfgack falls; req_err=0.
//  T2 read: req 1, web=1, ad=2'b10; FLL returns cfgq=32'h0000_1234 with cfgack.
//     -> cfgweb=1 throughout; req_rdata=32'h00001234 in the req_done[1] cycle.
//  T3 contention: req_valid=2'b11 held from reset; repeat 4 transactions.
//     -> grants 0,1,0,1; no cfgreq overlap; each req_done is preceded by cfgack 1->0.
//  T4 capture: change req_d[0] to 32'hFFFF_FFFF one cycle after grant.
//     -> cfgd keeps the original value until req_done.
//  T5 reset mid-op: assert rst_n=0 while in REQ, asynchronously to ref_clk.
//     -> cfgreq=0, cfgweb=1 without waiting for a clock edge; no req_done; after release, IDLE accepts new request.
//  T6 timeout (macro on, TIMEOUT_CYC=16): never assert cfgack.
//     -> req_done[0]=req_err[0]=1, 17 cycles after cfgreq rose; req_rdata=0; cfgreq=0.

Source files
------------

// File: rtl/fll_cfg_arb.sv
// rtl/fll_cfg_arb.sv - round-robin arbiter for the shared FLL config port; FLL_CFG_ARB_TIMEOUT_EN adds an ack watchdog
module fll_cfg_arb #(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 ref_clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_web,
  input  logic [2*NREQ-1:0]    req_ad,
  input  logic [32*NREQ-1:0]   req_d,
  output logic [NREQ-1:0]      req_done,
  output logic [NREQ-1:0]      req_err,
  output logic [31:0]          req_rdata,
  output logic                 cfgreq,
  output logic                 cfgweb,
  output logic [1:0]           cfgad,
  output logic [31:0]          cfgd,
  input  logic                 cfgack,
  input  logic [31:0]          cfgq
);

  localparam int OW = $clog2(NREQ);
  localparam logic [OW-1:0] LAST_IDX = OW'(NREQ - 1);
  localparam logic [OW-1:0] ONE_IDX  = OW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_q, rr_d;
  logic [OW-1:0]   grant_idx, next_idx;
  logic            grant_valid;
  logic            timeout;
  logic [31:0]     rdata_q, rdata_d;
  logic            cfgreq_d, cfgweb_d;
  logic [1:0]      cfgad_d;
  logic [31:0]     cfgd_d;
  logic [NREQ-1:0] done_d, err_d;
  logic [31:0]     req_rdata_d;
  logic [NREQ-1:0] eligible;
  logic [1:0]      ad_arr [NREQ];
  logic [31:0]     d_arr  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign ad_arr[g] = req_ad[2*g +: 2];
    assign d_arr[g]  = req_d[32*g +: 32];
  end

  // The owner that just completed still has req_valid high during its req_done cycle; mask it so it is not re-granted.
  assign eligible = req_valid & ~req_done;
  assign next_idx = (owner_q == LAST_IDX) ? '0 : owner_q + ONE_IDX;

  // Round-robin pick: first eligible requester at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    int            idx;
    logic [OW-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = rr_q;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = idx[OW-1:0];
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

`ifdef FLL_CFG_ARB_TIMEOUT_EN
  localparam int CW = 16;
  logic [CW-1:0] tmo_cnt;

  // Ack watchdog: cleared on grant, counts through REQ and RELEASE, holds in IDLE.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state_q == IDLE) begin
      if (grant_valid) tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  assign timeout = (state_q != IDLE) && (tmo_cnt == CW'(TIMEOUT_CYC));
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = |TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  // State register plus all registered outputs and datapath.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      rdata_q   <= '0;
      cfgreq    <= 1'b0;
      cfgweb    <= 1'b1;
      cfgad     <= '0;
      cfgd      <= '0;
      req_done  <= '0;
      req_err   <= '0;
      req_rdata <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      rdata_q   <= rdata_d;
      cfgreq    <= cfgreq_d;
      cfgweb    <= cfgweb_d;
      cfgad     <= cfgad_d;
      cfgd      <= cfgd_d;
      req_done  <= done_d;
      req_err   <= err_d;
      req_rdata <= req_rdata_d;
    end
  end

  // Next-state: grant, wait for ack, wait for ack release; watchdog aborts to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = REQ;
      REQ:     if (timeout) state_d = IDLE;
               else if (cfgack) state_d = RELEASE;
      RELEASE: if (timeout || !cfgack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: capture on grant, hold while owned, complete or abort.
  always_comb begin
    owner_d     = owner_q;
    rr_d        = rr_q;
    rdata_d     = rdata_q;
    cfgreq_d    = cfgreq;
    cfgweb_d    = cfgweb;
    cfgad_d     = cfgad;
    cfgd_d      = cfgd;
    done_d      = '0;
    err_d       = '0;
    req_rdata_d = req_rdata;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d  = grant_idx;
          cfgreq_d = 1'b1;
          cfgweb_d = req_web[grant_idx];
          cfgad_d  = ad_arr[grant_idx];
          cfgd_d   = d_arr[grant_idx];
        end
      end
      REQ, RELEASE: begin
        if (timeout) begin
          cfgreq_d        = 1'b0;
          cfgweb_d        = 1'b1;
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
          req_rdata_d     = '0;
          rr_d            = next_idx;
        end else if (state_q == REQ) begin
          if (cfgack) begin
            rdata_d  = cfgweb ? cfgq : '0;
            cfgreq_d = 1'b0;
            cfgweb_d = 1'b1;
          end
        end else if (!cfgack) begin
          done_d[owner_q] = 1'b1;
          req_rdata_d     = rdata_q;
          rr_d            = next_idx;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fll_cfg_arb.sv
// tb/tb_fll_cfg_arb.sv - randomized self-checking bench for fll_cfg_arb
module tb_fll_cfg_arb;

  localparam int N   = 3;
  localparam int TMO = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_web;
  logic [2*N-1:0]   req_ad;
  logic [32*N-1:0]  req_d;
  logic [N-1:0]     req_done, req_err;
  logic [31:0]      req_rdata;
  logic             cfgreq, cfgweb;
  logic [1:0]       cfgad;
  logic [31:0]      cfgd;
  logic             cfgack;
  logic [31:0]      cfgq;

  always #5 clk = ~clk;

  fll_cfg_arb #(.NREQ(N), .TIMEOUT_CYC(TMO)) dut (
    .ref_clk   (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_web   (req_web),
    .req_ad    (req_ad),
    .req_d     (req_d),
    .req_done  (req_done),
    .req_err   (req_err),
    .req_rdata (req_rdata),
    .cfgreq    (cfgreq),
    .cfgweb    (cfgweb),
    .cfgad     (cfgad),
    .cfgd      (cfgd),
    .cfgack    (cfgack),
    .cfgq      (cfgq)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // requester side
  bit          v [N];
  bit          w [N];
  bit [1:0]    a [N];
  bit [31:0]   d [N];
  int          ph [N];
  int          raise_pct;
  bit [N-1:0]  raise_en;
  bit          chg_en;

  // FLL side
  bit          ack;
  logic [31:0] q;
  int          dly;
  bit          fll_en;
  bit          fix_q_en;
  logic [31:0] fix_q;

  // transaction-level reference
  int          ptr, owner;
  bit          busy, rel;
  logic [N-1:0] exp_done, last_done;
  logic [31:0] exp_rd, last_rd;
  bit          cw;
  logic [1:0]  ca;
  logic [31:0] cd;
  int          n_done;
  int          grant_log[$];

  function automatic int pick(input logic [N-1:0] elig, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (elig[j]) return j;
    end
    return -1;
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = v[i];
      req_web[i]        = w[i];
      req_ad[2*i +: 2]  = a[i];
      req_d[32*i +: 32] = d[i];
    end
    cfgack = ack;
    cfgq   = q;
  endtask

  task automatic model_reset();
    ptr = 0; owner = -1; busy = 0; rel = 0; last_done = '0;
    ack = 0; dly = 0; q = '0;
    for (int i = 0; i < N; i++) begin
      v[i] = 0; w[i] = 0; a[i] = '0; d[i] = '0; ph[i] = 0;
    end
    apply();
  endtask

  task automatic raise(input int i, input bit web, input bit [1:0] ad, input bit [31:0] dd);
    v[i] = 1; w[i] = web; a[i] = ad; d[i] = dd; ph[i] = 1;
    apply();
  endtask

  task automatic step();
    logic [N-1:0] elig;
    int p;
    @(negedge clk);
    exp_done = '0;
    if (busy) begin
      if (ack) begin
        check("cfgreq_drop", cfgreq, 0);
        check("cfgweb_idle", cfgweb, 1);
        exp_rd = cw ? q : 32'h0;
        busy = 0; rel = 1;
      end else begin
        check("cfgreq_hold", cfgreq, 1);
        check("cfgweb_hold", cfgweb, cw);
        check("cfgad_hold", cfgad, ca);
        check("cfgd_hold", cfgd, cd);
      end
    end else if (rel) begin
      check("cfgreq_rel", cfgreq, 0);
      if (!ack) begin
        exp_done[owner] = 1'b1;
        check("req_rdata", req_rdata, exp_rd);
        last_rd = req_rdata;
        ptr = (owner + 1) % N;
        rel = 0;
        n_done++;
      end
    end else begin
      for (int i = 0; i < N; i++) elig[i] = v[i] & ~last_done[i];
      p = pick(elig, ptr);
      if (p >= 0) begin
        check("grant_cfgreq", cfgreq, 1);
        check("grant_cfgweb", cfgweb, w[p]);
        check("grant_cfgad", cfgad, a[p]);
        check("grant_cfgd", cfgd, d[p]);
        busy = 1; owner = p; cw = w[p]; ca = a[p]; cd = d[p];
        grant_log.push_back(p);
      end else begin
        check("idle_cfgreq", cfgreq, 0);
      end
    end
    check("req_done", req_done, exp_done);
    check("req_err", req_err, 0);
    last_done = exp_done;

    for (int i = 0; i < N; i++) begin
      if (ph[i] == 1 && exp_done[i]) begin
        if ($urandom % 2 == 1) begin v[i] = 0; ph[i] = 0; end
        else ph[i] = 2;
      end else if (ph[i] == 2) begin
        v[i] = 0; ph[i] = 0;
      end else if (ph[i] == 0 && raise_en[i] && int'($urandom_range(99, 0)) < raise_pct) begin
        v[i] = 1; w[i] = 1'($urandom); a[i] = 2'($urandom); d[i] = $urandom; ph[i] = 1;
      end else if (ph[i] == 1 && chg_en && (busy || rel) && owner == i && $urandom % 2 == 1) begin
        w[i] = 1'($urandom); a[i] = 2'($urandom); d[i] = $urandom;
      end
    end

    if (fll_en) begin
      if (!ack) begin
        if (cfgreq) begin
          if (dly == 0) begin
            ack = 1; q = fix_q_en ? fix_q : $urandom; dly = $urandom_range(3, 0);
          end else dly--;
        end else begin
          q = $urandom;
        end
      end else if (!cfgreq) begin
        if (dly == 0) begin ack = 0; dly = $urandom_range(3, 0); end
        else dly--;
      end
    end
    apply();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_busy(input string tag);
    int k = 0;
    while (!busy && k < 50) begin step(); k++; end
    check(tag, busy, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int k, base;
    rst_n = 1'b1;
    raise_pct = 0; raise_en = '1; chg_en = 0;
    fll_en = 1; fix_q_en = 0; fix_q = '0;
    n_done = 0; last_rd = '0; exp_rd = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #10;
    check("rst_cfgreq", cfgreq, 0);
    check("rst_cfgweb", cfgweb, 1);
    check("rst_cfgad", cfgad, 0);
    check("rst_cfgd", cfgd, 0);
    check("rst_req_done", req_done, 0);
    check("rst_req_err", req_err, 0);
    check("rst_req_rdata", req_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single write from requester 0
    raise(0, 1'b0, 2'b01, 32'hC088_0010);
    run(20);
    check("t1_done_count", n_done, 1);

    // read by requester 1
    fix_q_en = 1; fix_q = 32'h0000_1234;
    raise(1, 1'b1, 2'b10, 32'hDEAD_BEEF);
    run(20);
    check("t2_done_count", n_done, 2);
    check("t2_rdata", last_rd, 32'h0000_1234);
    fix_q_en = 0;

    // contention between 0 and 1, both re-requesting continuously
    grant_log.delete();
    raise_en = 3'b011; raise_pct = 100;
    raise(0, 1'b0, 2'b00, 32'h1111_0000);
    raise(1, 1'b0, 2'b11, 32'h2222_0000);
    k = 0;
    while (grant_log.size() < 4 && k < 200) begin step(); k++; end
    raise_pct = 0;
    run(60);
    check("t3_count", grant_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      check("t3_grant", (i < grant_log.size()) ? grant_log[i] : -1, i % 2);

    // captured data must survive requester changes after grant
    raise(0, 1'b0, 2'b11, 32'h1357_9BDF);
    wait_busy("t4_grant_wait");
    d[0] = 32'hFFFF_FFFF;
    apply();
    run(20);
    check("t4_last_cfgd", cd, 32'h1357_9BDF);

    // random traffic from all requesters
    raise_en = '1; raise_pct = 30; chg_en = 1;
    run(1500);
    raise_pct = 0; chg_en = 0;
    run(60);

    // asynchronous reset mid-transaction
    base = n_done;
    raise(2, 1'b0, 2'b10, 32'hA5A5_5A5A);
    wait_busy("t5_grant_wait");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_cfgreq_async", cfgreq, 0);
    check("t5_cfgweb_async", cfgweb, 1);
    check("t5_done_async", req_done, 0);
    model_reset();
    run(3);
    rst_n = 1'b1;
    check("t5_no_done", n_done, base);
    raise(1, 1'b0, 2'b01, 32'h0BAD_F00D);
    run(20);
    check("t5_new_req", n_done, base + 1);

`ifdef FLL_CFG_ARB_TIMEOUT_EN
    // FLL never acknowledges: watchdog completes with error
    fll_en = 0;
    raise(0, 1'b1, 2'b01, 32'h0);
    k = 0;
    while (!cfgreq && k < 10) begin @(negedge clk); k++; end
    check("t6_cfgreq_rise", cfgreq, 1);
    k = 0;
    while (req_done == '0 && k < 40) begin @(negedge clk); k++; end
    check("t6_latency", k, 17);
    check("t6_done", req_done, 3'b001);
    check("t6_err", req_err, 3'b001);
    check("t6_rdata", req_rdata, 0);
    check("t6_cfgreq", cfgreq, 0);
    v[0] = 0; ph[0] = 0;
    apply();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
